// File: rtl/matmul_seq_controller_if.sv
// Control bundle between the matrix-multiply sequencer and its A/B/C memories and data path.
// The master side is the sequencer; the slave side is the memory/data-path environment.
interface matmul_seq_controller_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] m_last;
   logic [ADDR_WIDTH-1:0] k_last;
   logic [ADDR_WIDTH-1:0] n_last;

   logic                  busy;
   logic                  done;

   logic                  en_ReadMat_A;
   logic                  en_ReadMat_B;
   logic [ADDR_WIDTH-1:0] rowAddr_A;
   logic [ADDR_WIDTH-1:0] colAddr_A;
   logic [ADDR_WIDTH-1:0] rowAddr_B;
   logic [ADDR_WIDTH-1:0] colAddr_B;

   logic                  en_Mux;
   logic                  en_PPReg;
   logic                  en_FDReg;

   logic                  en_WriteMat_C;
   logic [ADDR_WIDTH-1:0] rowAddr_C;
   logic [ADDR_WIDTH-1:0] colAddr_C;

   modport master (
      input  start, m_last, k_last, n_last,
      output busy, done,
      output en_ReadMat_A, en_ReadMat_B, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B,
      output en_Mux, en_PPReg, en_FDReg,
      output en_WriteMat_C, rowAddr_C, colAddr_C
   );

   modport slave (
      output start, m_last, k_last, n_last,
      input  busy, done,
      input  en_ReadMat_A, en_ReadMat_B, rowAddr_A, colAddr_A, rowAddr_B, colAddr_B,
      input  en_Mux, en_PPReg, en_FDReg,
      input  en_WriteMat_C, rowAddr_C, colAddr_C
   );
endinterface

// File: rtl/matmul_seq_controller.sv
// Start/done sequencer for C = A*B with runtime dimensions; issues A/B reads, data-path
// enables and C writes, one C element every K+3 cycles in row-major order.
module matmul_seq_controller #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   matmul_seq_controller_if.master  bus
);

   if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("matmul_seq_controller: DATA_WIDTH must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FINAL,
      S_WRITE,
      S_DONE
   } state_t;

   typedef logic [ADDR_WIDTH-1:0] addr_t;

   state_t state_q;

   addr_t  i_q, j_q, k_q;
   addr_t  m_last_q, k_last_q, n_last_q;

   logic   busy_q;
   logic   done_q;
   logic   en_rd_q;
   logic   en_mux_q;
   logic   en_pp_q;
   logic   en_fd_q;
   logic   en_wr_q;

   addr_t  row_a_q, col_a_q;
   addr_t  row_b_q, col_b_q;
   addr_t  row_c_q, col_c_q;

   // Every output is a register loaded with the value belonging to the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: every register, including the latched dimensions, is cleared so no stale write can follow reset.
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         m_last_q <= '0;
         k_last_q <= '0;
         n_last_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         en_rd_q  <= 1'b0;
         en_mux_q <= 1'b0;
         en_pp_q  <= 1'b0;
         en_fd_q  <= 1'b0;
         en_wr_q  <= 1'b0;
         row_a_q  <= '0;
         col_a_q  <= '0;
         row_b_q  <= '0;
         col_b_q  <= '0;
         row_c_q  <= '0;
         col_c_q  <= '0;
      end else begin
         // NOTE: strobes default low every cycle, so each one is a single-state pulse; addresses are not defaulted and hold.
         done_q   <= 1'b0;
         en_rd_q  <= 1'b0;
         en_mux_q <= 1'b0;
         en_pp_q  <= 1'b0;
         en_fd_q  <= 1'b0;
         en_wr_q  <= 1'b0;

         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q  <= S_RUN;
                  m_last_q <= bus.m_last;
                  k_last_q <= bus.k_last;
                  n_last_q <= bus.n_last;
                  i_q      <= '0;
                  j_q      <= '0;
                  k_q      <= '0;
                  busy_q   <= 1'b1;
                  en_rd_q  <= 1'b1;
                  row_a_q  <= '0;
                  col_a_q  <= '0;
                  row_b_q  <= '0;
                  col_b_q  <= '0;
               end
            end

            S_RUN: begin
               if (k_q == k_last_q) begin
                  state_q  <= S_DRAIN;
                  en_pp_q  <= 1'b1;
                  en_mux_q <= (k_last_q != '0);
               end else begin
                  // The next RUN cycle consumes the data read for the current k.
                  k_q      <= k_q + 1'b1;
                  en_rd_q  <= 1'b1;
                  row_a_q  <= i_q;
                  col_a_q  <= k_q + 1'b1;
                  row_b_q  <= k_q + 1'b1;
                  col_b_q  <= j_q;
                  en_pp_q  <= 1'b1;
                  en_mux_q <= (k_q != '0);
               end
            end

            S_DRAIN: begin
               state_q <= S_FINAL;
               en_fd_q <= 1'b1;
            end

            S_FINAL: begin
               state_q <= S_WRITE;
               en_wr_q <= 1'b1;
               row_c_q <= i_q;
               col_c_q <= j_q;
            end

            S_WRITE: begin
               if (j_q < n_last_q) begin
                  state_q <= S_RUN;
                  j_q     <= j_q + 1'b1;
                  k_q     <= '0;
                  en_rd_q <= 1'b1;
                  row_a_q <= i_q;
                  col_a_q <= '0;
                  row_b_q <= '0;
                  col_b_q <= j_q + 1'b1;
               end else if (i_q < m_last_q) begin
                  state_q <= S_RUN;
                  i_q     <= i_q + 1'b1;
                  j_q     <= '0;
                  k_q     <= '0;
                  en_rd_q <= 1'b1;
                  row_a_q <= i_q + 1'b1;
                  col_a_q <= '0;
                  row_b_q <= '0;
                  col_b_q <= '0;
               end else begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.en_ReadMat_A  = en_rd_q;
   assign bus.en_ReadMat_B  = en_rd_q;
   assign bus.rowAddr_A     = row_a_q;
   assign bus.colAddr_A     = col_a_q;
   assign bus.rowAddr_B     = row_b_q;
   assign bus.colAddr_B     = col_b_q;
   assign bus.en_Mux        = en_mux_q;
   assign bus.en_PPReg      = en_pp_q;
   assign bus.en_FDReg      = en_fd_q;
   assign bus.en_WriteMat_C = en_wr_q;
   assign bus.rowAddr_C     = row_c_q;
   assign bus.colAddr_C     = col_c_q;

endmodule

// File: tb/tb_matmul_seq_controller.sv
// Directed bench for matmul_seq_controller: cycle-exact schedule checks plus a small
// behavioural data path whose C memory is compared against hand-computed products.
module tb_matmul_seq_controller;

   localparam int AW = 4;
   localparam int SZ = 1 << AW;

   logic clk;
   logic reset_n;
   logic clr_c;

   int n_checks;
   int n_errors;

   int a_mem [SZ][SZ];
   int b_mem [SZ][SZ];
   int c_mem [SZ][SZ];
   int c_exp [SZ][SZ];
   int a_dat, b_dat, pp_reg, fd_reg;

   matmul_seq_controller_if #(.ADDR_WIDTH(AW)) bus ();

   matmul_seq_controller #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [7:0] strobes = {bus.busy, bus.done, bus.en_ReadMat_A, bus.en_ReadMat_B,
                         bus.en_Mux, bus.en_PPReg, bus.en_FDReg, bus.en_WriteMat_C};
   wire [31:0] outs_all = {strobes, bus.rowAddr_A, bus.colAddr_A, bus.rowAddr_B,
                           bus.colAddr_B, bus.rowAddr_C, bus.colAddr_C};

   // Behavioural data path: synchronous reads, partial-product and final-data registers, C memory.
   always @(posedge clk) begin
      if (clr_c) begin
         for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
               c_mem[r][c] <= -1;
      end else if (bus.en_WriteMat_C) begin
         c_mem[bus.rowAddr_C][bus.colAddr_C] <= fd_reg;
      end
      if (bus.en_ReadMat_A) a_dat <= a_mem[bus.rowAddr_A][bus.colAddr_A];
      if (bus.en_ReadMat_B) b_dat <= b_mem[bus.rowAddr_B][bus.colAddr_B];
      if (bus.en_PPReg) pp_reg <= bus.en_Mux ? pp_reg + a_dat * b_dat : a_dat * b_dat;
      if (bus.en_FDReg) fd_reg <= pp_reg;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_c();
      clr_c = 1'b1;
      @(negedge clk);
      clr_c = 1'b0;
   endtask

   task automatic load_222();
      a_mem[0][0] = 1; a_mem[0][1] = 2; a_mem[1][0] = 3; a_mem[1][1] = 4;
      b_mem[0][0] = 5; b_mem[0][1] = 6; b_mem[1][0] = 7; b_mem[1][1] = 8;
      c_exp[0][0] = 19; c_exp[0][1] = 22; c_exp[1][0] = 43; c_exp[1][1] = 50;
      clear_c();
   endtask

   task automatic load_k1();
      a_mem[0][0] = 2; a_mem[1][0] = 3; a_mem[2][0] = 4;
      b_mem[0][0] = 5; b_mem[0][1] = 7;
      c_exp[0][0] = 10; c_exp[0][1] = 14;
      c_exp[1][0] = 15; c_exp[1][1] = 21;
      c_exp[2][0] = 20; c_exp[2][1] = 28;
      clear_c();
   endtask

   task automatic load_full();
      for (int r = 0; r < SZ; r++)
         for (int c = 0; c < SZ; c++) begin
            a_mem[r][c] = (r + 2 * c) % 7;
            b_mem[r][c] = (3 * r + c) % 5;
         end
      for (int r = 0; r < SZ; r++)
         for (int c = 0; c < SZ; c++) begin
            c_exp[r][c] = 0;
            for (int k = 0; k < SZ; k++)
               c_exp[r][c] += a_mem[r][k] * b_mem[k][c];
         end
      clear_c();
   endtask

   // Starts a run and checks every cycle against the (e+1)(K+3) write schedule.
   task automatic run(input string tag, input int ml, input int kl, input int nl,
                      input bit disturb, input bit hold, input int abort_cyc);
      int kk, total, e, p, pa, ei, ej, writes;
      logic [7:0]  exp_st;
      logic [15:0] exp_ab;
      logic [3:0]  f0, f1, f2, f3;
      kk     = kl + 1;
      total  = (ml + 1) * (nl + 1) * (kk + 3);
      writes = 0;
      @(negedge clk);
      bus.m_last = 4'(ml);
      bus.k_last = 4'(kl);
      bus.n_last = 4'(nl);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = hold;
      bus.m_last = 4'($urandom);
      bus.k_last = 4'($urandom);
      bus.n_last = 4'($urandom);
      for (int cyc = 1; cyc <= total + 1; cyc++) begin
         if (cyc <= total) begin
            e  = (cyc - 1) / (kk + 3);
            p  = (cyc - 1) % (kk + 3);
            ei = e / (nl + 1);
            ej = e % (nl + 1);
            pa = (p < kk) ? p : kk - 1;
            exp_st = {1'b1, 1'b0, p < kk, p < kk, (p >= 2 && p <= kk),
                      (p >= 1 && p <= kk), p == kk + 1, p == kk + 2};
            check($sformatf("%s.c%0d.strobes", tag, cyc), 32'(strobes), 32'(exp_st));
            f0 = 4'(ei); f1 = 4'(pa); f2 = 4'(ej);
            exp_ab = {f0, f1, f1, f2};
            check($sformatf("%s.c%0d.addr_ab", tag, cyc),
                  32'({bus.rowAddr_A, bus.colAddr_A, bus.rowAddr_B, bus.colAddr_B}), 32'(exp_ab));
            if (p == kk + 2) begin
               f3 = 4'(ej);
               check($sformatf("%s.c%0d.addr_c", tag, cyc),
                     32'({bus.rowAddr_C, bus.colAddr_C}), 32'({f0, f3}));
               writes++;
            end
         end else begin
            check($sformatf("%s.c%0d.done_cycle", tag, cyc), 32'(strobes), 32'h40);
         end
         if (cyc == abort_cyc) begin
            bus.start = 1'b0;
            #1 reset_n = 1'b0;
            #1 check($sformatf("%s.async_clear", tag), outs_all, 32'h0);
            for (int w = 0; w < 3; w++) begin
               @(negedge clk);
               check($sformatf("%s.held_rst%0d", tag, w), outs_all, 32'h0);
            end
            reset_n = 1'b1;
            @(negedge clk);
            check($sformatf("%s.after_release", tag), outs_all, 32'h0);
            return;
         end
         if (cyc <= total) begin
            bus.start = hold || (disturb && (cyc == 3 || cyc == 10));
            if (disturb && (cyc == 3 || cyc == 10)) begin
               bus.m_last = 4'(cyc);
               bus.k_last = 4'(cyc + 1);
               bus.n_last = 4'(cyc + 2);
            end
            @(negedge clk);
         end
      end
      check($sformatf("%s.write_count", tag), 32'(writes), 32'((ml + 1) * (nl + 1)));
      for (int r = 0; r <= ml; r++)
         for (int c = 0; c <= nl; c++)
            check($sformatf("%s.C[%0d][%0d]", tag, r, c), 32'(c_mem[r][c]), 32'(c_exp[r][c]));
   endtask

   initial begin
      int waited;
      n_checks   = 0;
      n_errors   = 0;
      clr_c      = 1'b0;
      reset_n    = 1'b0;
      bus.start  = 1'b1;
      bus.m_last = 4'd1;
      bus.k_last = 4'd1;
      bus.n_last = 4'd1;

      // Reset held with start high: nothing may be accepted.
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("reset.c%0d.outs", c), outs_all, 32'h0);
      end
      bus.start = 1'b0;
      reset_n   = 1'b1;
      repeat (2) @(negedge clk);
      check("reset.idle_after_release", outs_all, 32'h0);

      load_222();
      run("m2k2n2", 1, 1, 1, 1'b0, 1'b0, 0);

      load_k1();
      run("k1", 2, 0, 1, 1'b0, 1'b0, 0);

      load_222();
      run("ignored_start", 1, 1, 1, 1'b1, 1'b0, 0);

      load_222();
      run("abort", 1, 1, 1, 1'b0, 1'b0, 7);
      load_222();
      run("after_abort", 1, 1, 1, 1'b0, 1'b0, 0);

      // start held high across DONE: a new run must begin shortly after.
      load_222();
      run("held_start", 1, 1, 1, 1'b0, 1'b1, 0);
      waited = 0;
      while (!bus.busy && waited < 4) begin
         @(negedge clk);
         waited++;
      end
      check("held_start.restart", 32'(bus.busy), 32'h1);
      bus.start = 1'b0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      reset_n   = 1'b1;
      @(negedge clk);

      load_full();
      run("full", 15, 15, 15, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
